mem_addr_rs: RTL

Reservation station and address-generation unit for loads and stores in the out-of-order core. It sits between rename/dispatch and the memory queue. It holds memory ops until their source physical registers are ready, snooping the CDBs for wakeup. It reads the register file, computes the effective address rs1 + imm, and delivers address, store data and the queue index to the memory queue one cycle after issue.

---
 rtl/rv32i_types.sv | 33 +++
 rtl/mem_rs_prio_enc.sv | 24 ++
 rtl/mem_addr_rs.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I core types: base opcodes, CDB broadcast and memory RS entry.
package rv32i_types;

  typedef enum logic [6:0] {
    op_b_lui   = 7'b0110111,
    op_b_auipc = 7'b0010111,
    op_b_jal   = 7'b1101111,
    op_b_jalr  = 7'b1100111,
    op_b_br    = 7'b1100011,
    op_b_load  = 7'b0000011,
    op_b_store = 7'b0100011,
    op_b_imm   = 7'b0010011,
    op_b_reg   = 7'b0110011
  } rv32i_opcode;

  typedef struct packed {
    logic        valid;
    logic [5:0]  pd_s;
    logic [31:0] rd_v;
  } cdb_t;

  typedef struct packed {
    logic        valid;
    logic        is_store;
    logic [31:0] imm;
    logic [5:0]  ps1;
    logic        ps1_rdy;
    logic [5:0]  ps2;
    logic        ps2_rdy;
    logic [5:0]  mem_idx;
  } mem_rs_entry_t;

endpackage

// File: rtl/mem_rs_prio_enc.sv
// Lowest-index priority encoder: reports whether any request is set and
// the index of the lowest one.
module mem_rs_prio_enc #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan upward and keep the first hit.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (req[i] && !found) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_addr_rs.sv
// Memory-op reservation station with address generation. Holds loads and
// stores until their sources are ready, snoops the CDBs for wakeup, reads
// the register file for the selected entry and registers rs1 + imm, store
// data and the memory-queue slot one cycle after issue.
module mem_addr_rs
  import rv32i_types::*;
#(
  parameter int unsigned RS_DEPTH = 8,
  parameter int unsigned N_CDB    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dispatch_valid,
  input  logic [31:0] inst,
  input  logic [5:0]  ps1_s,
  input  logic [5:0]  ps2_s_in,
  input  logic        ps1_ready,
  input  logic        ps2_ready,
  input  logic [5:0]  mem_idx_in,
  input  cdb_t        cdb [N_CDB],
  output logic [5:0]  rf_ps1,
  output logic [5:0]  rf_ps2,
  input  logic [31:0] rf_v1,
  input  logic [31:0] rf_v2,
  output logic        full,
  output logic [31:0] addr,
  output logic        addr_valid,
  output logic [5:0]  mem_idx_out,
  output logic [31:0] store_wdata
);

  localparam int unsigned IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  mem_rs_entry_t       rs_q [RS_DEPTH];
  mem_rs_entry_t       new_ent;
  logic [RS_DEPTH-1:0] valid_vec;
  logic [RS_DEPTH-1:0] ready_vec;
  logic [RS_DEPTH-1:0] wake1;
  logic [RS_DEPTH-1:0] wake2;
  logic                disp_hit1;
  logic                disp_hit2;
  logic                disp_is_store;
  logic [31:0]         disp_imm;
  logic                free_found;
  logic [IDX_W-1:0]    free_idx;
  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic                unused_fields;

  // Occupancy and issue-eligibility vectors from registered entry state.
  always_comb begin
    valid_vec = '0;
    ready_vec = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      valid_vec[i] = rs_q[i].valid;
      ready_vec[i] = rs_q[i].valid && rs_q[i].ps1_rdy && rs_q[i].ps2_rdy;
    end
  end

  mem_rs_prio_enc #(.WIDTH(RS_DEPTH), .IDX_W(IDX_W)) u_free_enc (
    .req   (~valid_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  mem_rs_prio_enc #(.WIDTH(RS_DEPTH), .IDX_W(IDX_W)) u_sel_enc (
    .req   (ready_vec),
    .found (sel_found),
    .idx   (sel_idx)
  );

  assign full = &valid_vec;

  // CDB tag matches against stored entries and against the op being dispatched.
  always_comb begin
    wake1     = '0;
    wake2     = '0;
    disp_hit1 = 1'b0;
    disp_hit2 = 1'b0;
    for (int unsigned c = 0; c < N_CDB; c++) begin
      if (cdb[c].valid) begin
        if (cdb[c].pd_s == ps1_s)    disp_hit1 = 1'b1;
        if (cdb[c].pd_s == ps2_s_in) disp_hit2 = 1'b1;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
          if (cdb[c].pd_s == rs_q[i].ps1) wake1[i] = 1'b1;
          if (cdb[c].pd_s == rs_q[i].ps2) wake2[i] = 1'b1;
        end
      end
    end
  end

  assign disp_is_store = (inst[6:0] == op_b_store);
  assign disp_imm = disp_is_store ? {{20{inst[31]}}, inst[31:25], inst[11:7]}
                                  : {{20{inst[31]}}, inst[31:20]};

  // Build the entry written at dispatch; tag 0 and same-cycle CDB hits count as ready.
  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.is_store = disp_is_store;
    new_ent.imm      = disp_imm;
    new_ent.ps1      = ps1_s;
    new_ent.ps1_rdy  = (ps1_s == '0) || ps1_ready || disp_hit1;
    new_ent.ps2      = disp_is_store ? ps2_s_in : '0;
    new_ent.ps2_rdy  = !disp_is_store || (ps2_s_in == '0) || ps2_ready || disp_hit2;
    new_ent.mem_idx  = mem_idx_in;
  end

  // Register-file read ports follow the selected entry, else idle at 0.
  always_comb begin
    rf_ps1 = '0;
    rf_ps2 = '0;
    if (sel_found) begin
      rf_ps1 = rs_q[sel_idx].ps1;
      rf_ps2 = rs_q[sel_idx].ps2;
    end
  end

  // Fold CDB payload and instruction bits this unit does not consume.
  always_comb begin
    unused_fields = ^inst[19:12];
    for (int unsigned c = 0; c < N_CDB; c++) begin
      unused_fields = unused_fields ^ (^cdb[c].rd_v);
    end
  end

  // Entry wakeup, issue/free, dispatch write and registered AGU outputs.
  // Dispatch targets a slot that was free before this edge, so it never
  // collides with the slot being freed by issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        rs_q[i] <= '0;
      end
      addr_valid  <= 1'b0;
      addr        <= '0;
      store_wdata <= '0;
      mem_idx_out <= '0;
    end else begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        if (wake1[i]) rs_q[i].ps1_rdy <= 1'b1;
        if (wake2[i]) rs_q[i].ps2_rdy <= 1'b1;
      end
      addr_valid <= sel_found;
      if (sel_found) begin
        rs_q[sel_idx].valid <= 1'b0;
        addr        <= rf_v1 + rs_q[sel_idx].imm;
        store_wdata <= rs_q[sel_idx].is_store ? rf_v2 : '0;
        mem_idx_out <= rs_q[sel_idx].mem_idx;
      end
      if (dispatch_valid && free_found) begin
        rs_q[free_idx] <= new_ent;
      end
    end
  end

endmodule
